// File: rtl/ether_tx_framer_if.sv
// Signal bundle between the frame requester/payload source and the TX framer.
// Payload handshake: a beat transfers on a rising clk edge where axiiv && axiir;
// axiilast is only meaningful on such a beat. Frame output has no backpressure.
interface ether_tx_framer_if #(
  parameter int N = 2
);
  logic         start;
  logic [47:0]  dest_mac;
  logic [15:0]  ethertype;
  logic [47:0]  my_mac;
  logic         axiiv;
  logic [N-1:0] axiid;
  logic         axiilast;
  logic         axiir;
  logic         axiov;
  logic [N-1:0] axiod;
  logic         busy;
  logic         err;

  modport master (
    output start, dest_mac, ethertype, my_mac, axiiv, axiid, axiilast,
    input  axiir, axiov, axiod, busy, err
  );

  modport slave (
    input  start, dest_mac, ethertype, my_mac, axiiv, axiid, axiilast,
    output axiir, axiov, axiod, busy, err
  );
endinterface

// File: rtl/ether_tx_framer.sv
// Ethernet TX framer: emits dest/src/type header, streams payload, pads to the
// minimum frame size and holds busy through the inter-frame gap.
module ether_tx_framer #(
  parameter int N                 = 2,
  parameter int MIN_PAYLOAD_BYTES = 46,
  parameter int MAX_PAYLOAD_BYTES = 1500,
  parameter int IFG_BITS          = 96
) (
  input  logic               clk,
  input  logic               rst,
  ether_tx_framer_if.slave   bus,
  output logic [2:0]         dbg_state
);

  localparam int BPB       = 8 / N;
  localparam int HDR_BEATS = 112 / N;
  localparam int MIN_BEATS = MIN_PAYLOAD_BYTES * 8 / N;
  localparam int MAX_BEATS = MAX_PAYLOAD_BYTES * 8 / N;
  localparam int GAP_CYC   = IFG_BITS / N;
  localparam int CW        = $clog2(MAX_BEATS + 1);
  localparam int HW        = $clog2(HDR_BEATS);
  localparam int GW        = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    PAD     = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t          state;
  logic [111:0]    shreg;
  logic [HW-1:0]   hdr_cnt;
  logic [CW-1:0]   pay_cnt;
  logic [GW-1:0]   gap_cnt;

  logic [111:0]    hdr_word;
  logic            hdr_last;
  logic [CW-1:0]   pay_nxt;
  logic            pay_done;

  assign hdr_word  = {bus.dest_mac, bus.my_mac, bus.ethertype};
  assign hdr_last  = (state == HEADER) && (hdr_cnt == HW'(HDR_BEATS - 1));
  // Ready opens one cycle early so the first payload beat follows the header directly.
  assign bus.axiir = hdr_last || (state == PAYLOAD);
  assign pay_nxt   = pay_cnt + CW'(1);
  assign pay_done  = (pay_nxt >= CW'(MIN_BEATS)) && ((pay_nxt % CW'(BPB)) == '0);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      hdr_cnt   <= '0;
      pay_cnt   <= '0;
      gap_cnt   <= '0;
      bus.axiov <= 1'b0;
      bus.axiod <= '0;
      bus.busy  <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      bus.err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg     <= hdr_word << N;
            hdr_cnt   <= '0;
            pay_cnt   <= '0;
            bus.axiov <= 1'b1;
            bus.axiod <= hdr_word[111 -: N];
            bus.busy  <= 1'b1;
            state     <= HEADER;
          end
        end
        HEADER: begin
          if (!hdr_last) begin
            bus.axiod <= shreg[111 -: N];
            shreg     <= shreg << N;
            hdr_cnt   <= hdr_cnt + HW'(1);
          end
        end
        PAYLOAD: begin
          state <= PAYLOAD;
        end
        PAD: begin
          bus.axiov <= 1'b1;
          bus.axiod <= '0;
          pay_cnt   <= pay_nxt;
          if (pay_done) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          bus.axiov <= 1'b0;
          bus.axiod <= '0;
          if (gap_cnt == GW'(GAP_CYC)) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Payload acceptance; gap_cnt starts at 1 on abort because axiov is already low.
      if (bus.axiir) begin
        if (!bus.axiiv || (pay_cnt == CW'(MAX_BEATS))) begin
          bus.axiov <= 1'b0;
          bus.axiod <= '0;
          bus.err   <= 1'b1;
          state     <= GAP;
          gap_cnt   <= GW'(1);
        end else begin
          bus.axiov <= 1'b1;
          bus.axiod <= bus.axiid;
          pay_cnt   <= pay_nxt;
          if (bus.axiilast) begin
            state   <= pay_done ? GAP : PAD;
            gap_cnt <= '0;
          end else begin
            state   <= PAYLOAD;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ether_tx_framer.sv
// Directed bench for ether_tx_framer: a table of frame scenarios scored against
// a header/payload/pad expected queue, plus reset-mid-header and reset checks.
module tb_ether_tx_framer;
  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dbg_state;

  ether_tx_framer_if #(.N(N)) bus();

  ether_tx_framer #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0] dest_c = 48'h42_04_20_42_04_20;
  logic [47:0] my_c   = 48'h02_00_00_00_00_01;
  logic [15:0] type_c = 16'h0800;

  typedef struct {
    int pattern;    // 0: byte k = k, 1: all 0xFF
    int n_send;     // beats the source is willing to offer
    int last_at;    // beat index carrying axiilast, -1 none
    int under_at;   // beat index where axiiv drops, -1 none
    int start_mid;  // cycle of a stray start pulse, -1 none
    int exp_ov;     // axiov-high cycles
    int exp_pay;    // payload + pad beats transmitted
    int exp_err;    // err-high cycles
  } vec_t;

  vec_t vec[5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] dib(input int pat, input int k);
    logic [7:0] b;
    int sh;
    b  = (pat == 1) ? 8'hFF : 8'(k / 4);
    sh = 7 - 2 * (k % 4);
    return b[sh -: 2];
  endfunction

  // Caller is positioned just after a negedge; returns at the negedge where busy is low.
  task automatic run_frame(input int i);
    vec_t v;
    logic [1:0] got_q[$];
    logic [1:0] exp_q[$];
    logic [111:0] hdr;
    int cyc, sent, ov, rises, errs, gap, bad;
    bit prev_ov, seen, done;
    v = vec[i];
    cyc = 0; sent = 0; ov = 0; rises = 0; errs = 0; gap = 0; bad = 0;
    prev_ov = 0; seen = 0; done = 0;

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check($sformatf("vec%0d_accept", i), bus.busy, 1);

    while (!done && cyc < 8000) begin
      if (bus.axiov) begin
        got_q.push_back(bus.axiod);
        ov++;
        if (!prev_ov) rises++;
        seen = 1;
      end else if (bus.busy && seen) begin
        gap++;
      end
      prev_ov = bus.axiov;
      errs += int'(bus.err);
      if (!bus.busy) done = 1;

      if (!done) begin
        bus.start    = (cyc == v.start_mid);
        bus.axiilast = 1'b0;
        bus.axiiv    = 1'b0;
        if (bus.axiir && sent != v.under_at && sent < v.n_send) begin
          bus.axiiv    = 1'b1;
          bus.axiid    = dib(v.pattern, sent);
          bus.axiilast = (sent == v.last_at);
          sent++;
        end
        @(negedge clk);
        cyc++;
      end else begin
        bus.start    = 1'b0;
        bus.axiiv    = 1'b0;
        bus.axiilast = 1'b0;
      end
    end
    check($sformatf("vec%0d_timeout", i), int'(done), 1);

    hdr = {dest_c, my_c, type_c};
    for (int j = 0; j < 56; j++) exp_q.push_back(hdr[111 - 2*j -: 2]);
    for (int k = 0; k < v.exp_pay; k++)
      exp_q.push_back((v.last_at >= 0 && k > v.last_at) ? 2'b00 : dib(v.pattern, k));

    check($sformatf("vec%0d_width", i), ov, v.exp_ov);
    check($sformatf("vec%0d_rises", i), rises, 1);
    check($sformatf("vec%0d_err", i), errs, v.exp_err);
    check($sformatf("vec%0d_gap", i), gap, 48);
    check($sformatf("vec%0d_beat_count", i), got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      if (got_q[k] !== exp_q[k]) bad++;
    check($sformatf("vec%0d_beat_data", i), bad, 0);
    check($sformatf("vec%0d_idle", i), int'(dbg_state), 0);

    if (i == 0 && got_q.size() > 56) begin
      check("min_dibit0", got_q[0], 1);
      check("min_dibit1", got_q[1], 0);
      check("min_dibit2", got_q[2], 0);
      check("min_dibit3", got_q[3], 2);
      check("min_beat56", got_q[56], 0);
    end
  endtask

  initial begin
    vec[0] = '{0, 184,  183, -1, 250, 240,  184,  0};  // minimum frame, stray start in gap
    vec[1] = '{1, 40,   39,  -1, -1,  240,  184,  0};  // 10 bytes of 0xFF, padded
    vec[2] = '{0, 243,  242, -1, -1,  300,  244,  0};  // partial byte, one pad beat
    vec[3] = '{0, 184,  -1,  20, -1,  76,   20,   1};  // underrun at beat 20
    vec[4] = '{0, 6004, -1,  -1, 100, 6056, 6000, 1};  // oversize, stray start mid-frame

    bus.start     = 1'b0;
    bus.dest_mac  = dest_c;
    bus.my_mac    = my_c;
    bus.ethertype = type_c;
    bus.axiiv     = 1'b0;
    bus.axiid     = '0;
    bus.axiilast  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_axiov", bus.axiov, 0);
    check("rst_axiod", bus.axiod, 0);
    check("rst_axiir", bus.axiir, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_err",   bus.err, 0);
    check("rst_state", int'(dbg_state), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_frame(i);

    // Reset while header beat 10 is on the wire.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("hdr_on", bus.axiov, 1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_axiov", bus.axiov, 0);
    check("midrst_busy",  bus.busy, 0);
    check("midrst_state", int'(dbg_state), 0);
    rst = 1'b1;
    @(negedge clk);
    run_frame(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
